// File: rtl/swap_pair_fifo_if.sv
// Handshake bundle between the swap-stage pair source, swap_pair_fifo and its consumer.
// The master modport is the producer/consumer side and the slave modport is the FIFO side.
interface swap_pair_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_c;
  logic [WIDTH-1:0]         in_d;
  logic                     in_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_c;
  logic [WIDTH-1:0]         out_d;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic [7:0]               drop_cnt;

  modport master (
    output in_valid, in_c, in_d, out_ready,
    input  in_ready, out_valid, out_c, out_d, count, drop_cnt
  );

  modport slave (
    input  in_valid, in_c, in_d, out_ready,
    output in_ready, out_valid, out_c, out_d, count, drop_cnt
  );
endinterface

// File: rtl/swap_pair_fifo.sv
// Pair FIFO behind the non-stalling swap stage: absorbs rate mismatch and counts overflow drops.
// Define PAIR_SORT_EN to store each pair as (min, max) instead of verbatim.
module swap_pair_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  swap_pair_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_q, drop_d;

  logic full, empty, push, pop, drop;
  logic [2*WIDTH-1:0] wr_data;
  logic [2*WIDTH-1:0] head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = bus.in_valid && (!full || pop);
  assign drop  = bus.in_valid && full && !pop;

`ifdef PAIR_SORT_EN
  assign wr_data = (bus.in_d < bus.in_c) ? {bus.in_d, bus.in_c} : {bus.in_c, bus.in_d};
`else
  assign wr_data = {bus.in_c, bus.in_d};
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage carries no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head          = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_c     = head[2*WIDTH-1:WIDTH];
  assign bus.out_d     = head[WIDTH-1:0];
  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full;
  assign bus.count     = count_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_swap_pair_fifo.sv
// Randomized and directed bench for swap_pair_fifo against a queue-based reference model.
// The model follows PAIR_SORT_EN the same way as the design build.
module tb_swap_pair_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swap_pair_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) bus ();
  swap_pair_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  logic [15:0] model_q[$];
  int          model_drops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic logic [15:0] stored_form(input logic [7:0] c, input logic [7:0] d);
`ifdef PAIR_SORT_EN
    return (c <= d) ? {c, d} : {d, c};
`else
    return {c, d};
`endif
  endfunction

  task automatic model_apply(input logic iv, input logic [7:0] c, input logic [7:0] d, input logic ordy);
    bit was_full;
    bit popped;
    was_full = (model_q.size() == DEPTH);
    popped   = (model_q.size() != 0) && ordy;
    if (popped) void'(model_q.pop_front());
    if (iv) begin
      if (!was_full || popped) model_q.push_back(stored_form(c, d));
      else if (model_drops < 255) model_drops++;
    end
  endtask

  task automatic compare_all();
    logic [15:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 16'h0;
    check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
    check("out_c",     32'(bus.out_c),     32'(head[15:8]));
    check("out_d",     32'(bus.out_d),     32'(head[7:0]));
    check("count",     32'(bus.count),     32'(model_q.size()));
    check("in_ready",  32'(bus.in_ready),  32'(model_q.size() != DEPTH));
    check("drop_cnt",  32'(bus.drop_cnt),  32'(model_drops));
  endtask

  task automatic step(input logic iv, input logic [7:0] c, input logic [7:0] d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_c      = c;
    bus.in_d      = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    txn++;
    model_apply(iv, c, d, ordy);
    compare_all();
    $display("txn %0d iv=%0b c=%02h d=%02h ordy=%0b -> valid=%0b out=%02h/%02h count=%0d drops=%0d",
             txn, iv, c, d, ordy, bus.out_valid, bus.out_c, bus.out_d, bus.count, bus.drop_cnt);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_c      = '0;
    bus.in_d      = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_c", 32'(bus.out_c), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_drop",  32'(bus.drop_cnt), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single pair in, then out.
    step(1'b1, 8'h05, 8'h08, 1'b0);
    check("single_c", 32'(bus.out_c), 32'h05);
    check("single_d", 32'(bus.out_d), 32'h08);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("single_empty", 32'(bus.count), 32'd0);

    // Fill and overflow.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(2*i+1), 8'(2*i+2), 1'b0);
    check("ovf_count", 32'(bus.count), 32'd4);
    check("ovf_ready", 32'(bus.in_ready), 32'd0);
    check("ovf_drop",  32'(bus.drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("drain_c", 32'(bus.out_c), 32'(2*i+1));
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 8'(8'h50 + i), 1'b1);
    check("pp_count", 32'(bus.count), 32'd4);
    check("pp_drop",  32'(bus.drop_cnt), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b1);

    // Sort option.
    step(1'b1, 8'hFF, 8'h00, 1'b0);
`ifdef PAIR_SORT_EN
    check("sort_c", 32'(bus.out_c), 32'h00);
    check("sort_d", 32'(bus.out_d), 32'hFF);
`else
    check("sort_c", 32'(bus.out_c), 32'hFF);
    check("sort_d", 32'(bus.out_d), 32'h00);
`endif
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Randomized traffic with bursty consumer.
    for (int i = 0; i < 400; i++) begin
      logic iv, ordy;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 64 < 40) ? ($urandom_range(0, 1) == 1) : 1'b0;
      step(iv, 8'($urandom), 8'($urandom), ordy);
    end
    while (model_q.size() != 0) step(1'b0, 8'h00, 8'h00, 1'b1);

    // drop_cnt saturation.
    for (int i = 0; i < 300 + DEPTH; i++) step(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    check("sat_drop", 32'(bus.drop_cnt), 32'd255);
    step(1'b1, 8'h11, 8'h22, 1'b0);
    check("sat_hold", 32'(bus.drop_cnt), 32'd255);

    // Asynchronous reset between edges with 3 entries stored.
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_drop",  32'(bus.drop_cnt), 32'd0);
    check("arst_out_c", 32'(bus.out_c), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    model_q.delete();
    model_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hA1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 8'hD4, 1'b0);
    check("post_rst_c", 32'(bus.out_c), 32'(stored_form(8'hA1, 8'hB2) >> 8));
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/swap_pair_fifo.md
# swap_pair_fifo

Buffers byte pairs produced by the clocked swap stage (its sw_c/sw_d outputs) and hands them to a downstream consumer through a valid/ready handshake. The swap stage emits a pair every cycle and cannot stall, so this block absorbs rate mismatch, counts pairs lost to overflow, and optionally orders each pair as (min, max) on the way out. It sits directly downstream of the swap stage in the same clock domain.

## Interface
- WIDTH, 8, bit width of each pair element
- DEPTH, 4, number of pair entries; power of two, at least 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_c/in_d carry a pair this cycle
- in_c  input  WIDTH  first element (from swap stage sw_c)
- in_d  input  WIDTH  second element (from swap stage sw_d)
- in_ready  output  1  FIFO not full; informational only, upstream does not stall
- out_valid  output  1  head entry available
- out_c  output  WIDTH  head first element; 0 when empty
- out_d  output  WIDTH  head second element; 0 when empty
- out_ready  input  1  consumer accepts head this cycle
- count  output  clog2(DEPTH)+1  entries currently stored
- drop_cnt  output  8  pairs dropped on full, saturating

## Operation
- Storage: circular buffer of DEPTH entries of 2*WIDTH bits. Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy, 0..DEPTH.
- full = (count == DEPTH); empty = (count == 0); in_ready = !full; out_valid = !empty.
- Push: in_valid && (!full || pop) writes {in_c, in_d} at the write pointer and advances it.
- Pop: out_valid && out_ready advances the read pointer.
- Drop: in_valid && full && !pop. The pair is discarded, drop_cnt increments, and it holds at 255 (no wrap).
- Simultaneous push and pop:
  - When full, the push is accepted and count stays at DEPTH.
  - When empty, only the push takes effect (no fall-through) and count becomes 1.
- out_c/out_d are read combinationally from the head entry and are forced to 0 when empty.
- out_ready while empty is ignored.
- Reset (asserted at any time, including mid-transfer) immediately clears pointers, count, and drop_cnt. Stored contents are discarded.

## Timing
- Reset values: out_valid 0, out_c 0, out_d 0, count 0, drop_cnt 0, in_ready 1.
- Latency: a pair pushed at edge N is visible on out_c/out_d with out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- Output data is stable while out_valid=1 and out_ready=0.
- count, drop_cnt, and the pointers update only on the rising clk edge or asynchronously on rst.
- First edge after rst deasserts: normal operation. A push on that edge is accepted.

## Configuration
- PAIR_SORT_EN defined: at write time the entry stores {min(in_c,in_d), max(in_c,in_d)}, using an unsigned compare. Equal values are stored unchanged. Output ordering has no added latency.
- PAIR_SORT_EN undefined: the entry stores {in_c, in_d} verbatim.
- The handshake, counters, and timing are identical in both builds.

## Test plan
- Reset then single pair: rst pulse, then one cycle of in_valid with in_c=8'h05, in_d=8'h08, out_ready=0.
  - Next cycle: out_valid=1, out_c=05, out_d=08, count=1.
  - Raise out_ready for one cycle: out_valid=0, out_c=out_d=0, count=0.
- Fill and overflow (DEPTH=4): out_ready=0, six consecutive pairs (1,2),(3,4),(5,6),(7,8),(9,10),(11,12).
  - count=4, in_ready=0, drop_cnt=2.
  - Draining yields (1,2),(3,4),(5,6),(7,8) in order.
- Full with simultaneous push/pop: FIFO full, in_valid and out_ready both high for 3 cycles.
  - drop_cnt unchanged, count stays 4.
  - Output order preserved across pointer wrap.
- drop_cnt saturation: FIFO full, in_valid=1 for 300 cycles with out_ready=0.
  - drop_cnt=255 and remains 255.
- Sort option: push in_c=8'hFF, in_d=8'h00.
  - With PAIR_SORT_EN: out_c=00, out_d=FF.
  - Without PAIR_SORT_EN: out_c=FF, out_d=00.
- Async reset mid-operation: 3 entries stored, assert rst between clock edges.
  - out_valid, count, and drop_cnt go to 0 before the next edge.
  - After release, the first read returns the first pair pushed after reset.
